// File: rtl/poly_nco.sv
// Multi-voice sine NCO: per-voice phase accumulators share one registered wavetable.
// Optional macro POLY_NCO_INTERP_EN adds linear interpolation between table entries.

package poly_nco_pkg;

  localparam int WAVETABLE_N = 6;
  localparam int PHASE_INDEX_BITS = 24;
  localparam int PHASE_ACCUMULATOR_FRACTIONAL_BITS =
    PHASE_INDEX_BITS - WAVETABLE_N;
  localparam int C_FRACTIONAL_BITS = PHASE_ACCUMULATOR_FRACTIONAL_BITS;
  localparam int FREQ_BITS = 16;
  localparam int AMP_BITS = 16;

  typedef logic [FREQ_BITS-1:0] frequency_t;
  typedef logic signed [AMP_BITS-1:0] amplitude_t;
  typedef logic [PHASE_INDEX_BITS-1:0] phase_index_type;
  typedef logic [PHASE_INDEX_BITS-1:0] PAC_type;
  typedef logic [WAVETABLE_N-1:0] table_addr_t;

endpackage

module sine_wavetable
  import poly_nco_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        rd_en,
  input  table_addr_t rd_addr,
  output amplitude_t  rd_data
);

  amplitude_t data_q, data_d;

  // Quarter wave, 17 points: round(32767 * sin(pi*k/32)).
  function automatic amplitude_t quarter(input logic [4:0] k);
    case (k)
      5'd0:    quarter = 16'sd0;
      5'd1:    quarter = 16'sd3212;
      5'd2:    quarter = 16'sd6393;
      5'd3:    quarter = 16'sd9512;
      5'd4:    quarter = 16'sd12539;
      5'd5:    quarter = 16'sd15446;
      5'd6:    quarter = 16'sd18204;
      5'd7:    quarter = 16'sd20787;
      5'd8:    quarter = 16'sd23170;
      5'd9:    quarter = 16'sd25329;
      5'd10:   quarter = 16'sd27245;
      5'd11:   quarter = 16'sd28898;
      5'd12:   quarter = 16'sd30273;
      5'd13:   quarter = 16'sd31356;
      5'd14:   quarter = 16'sd32137;
      5'd15:   quarter = 16'sd32609;
      default: quarter = 16'sd32767;
    endcase
  endfunction

  function automatic amplitude_t sine_at(input table_addr_t a);
    logic [4:0] k;
    amplitude_t m;
    k = a[4] ? 5'd16 - {1'b0, a[3:0]} : {1'b0, a[3:0]};
    m = quarter(k);
    return a[5] ? -m : m;
  endfunction

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = sine_at(rd_addr);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign rd_data = data_q;

endmodule

module poly_nco
  import poly_nco_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int SAMPLE_RATE = 192_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample_tick,
  input  logic                      freq_we,
  input  logic [$clog2(VOICES)-1:0] freq_voice,
  input  frequency_t                freq_in,
  input  logic                      voice_on,
  input  logic                      phase_sync,
  output amplitude_t                out,
  output logic [$clog2(VOICES)-1:0] out_voice,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int VW = $clog2(VOICES);
  localparam int C_INT = int'(
    (real'(2 ** WAVETABLE_N) / real'(SAMPLE_RATE))
    * (2.0 ** C_FRACTIONAL_BITS));
  localparam PAC_type C = PAC_type'(C_INT);
  localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  logic            rst_sync_q;
  state_t          state_q, state_d;
  logic [VW-1:0]   idx_q, idx_d;
  frequency_t      freq_q [VOICES];
  frequency_t      freq_d [VOICES];
  logic [VOICES-1:0] en_q, en_d;
  phase_index_type phase_q [VOICES];
  phase_index_type phase_d [VOICES];
  logic            vld_q, vld_d;
  logic [VW-1:0]   vvoice_q, vvoice_d;
  logic            mute_q, mute_d;
  logic            overrun_q, overrun_d;
  amplitude_t      hold_q, hold_d;
  logic [VW-1:0]   hvoice_q, hvoice_d;

  logic            rd_en;
  table_addr_t     rd_addr;
  amplitude_t      tbl_data;
  table_addr_t     cur_addr;
  phase_index_type cur_inc;
  logic            last;
  amplitude_t      samp;

`ifdef POLY_NCO_INTERP_EN
  logic               sub_q, sub_d;
  table_addr_t        nxt_q, nxt_d;
  logic [7:0]         frac_q, frac_d;
  amplitude_t         a_q, a_d;
  logic signed [16:0] diff;
  logic signed [25:0] prod;
`endif

  // Release is synchronised; assertion still clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  sine_wavetable u_tbl (
    .clock   (clock),
    .rst_n   (rst_sync_q),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (tbl_data)
  );

  assign cur_addr = table_addr_t'(
    phase_q[idx_q] >> PHASE_ACCUMULATOR_FRACTIONAL_BITS);
  assign cur_inc = phase_index_type'(freq_q[idx_q]) * C;
  assign last = (idx_q == LAST);

  always_comb begin : ctrl
    state_d   = state_q;
    idx_d     = idx_q;
    freq_d    = freq_q;
    en_d      = en_q;
    phase_d   = phase_q;
    vld_d     = 1'b0;
    vvoice_d  = vvoice_q;
    mute_d    = mute_q;
    overrun_d = overrun_q | (sample_tick & (state_q != IDLE));
    rd_en     = 1'b0;
    rd_addr   = cur_addr;
`ifdef POLY_NCO_INTERP_EN
    sub_d  = sub_q;
    nxt_d  = nxt_q;
    frac_d = frac_q;
    a_d    = a_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
`ifdef POLY_NCO_INTERP_EN
        if (!sub_q) begin
          nxt_d    = cur_addr + table_addr_t'(1);
          frac_d   = phase_q[idx_q][PHASE_ACCUMULATOR_FRACTIONAL_BITS-1 -: 8];
          vvoice_d = idx_q;
          mute_d   = !en_q[idx_q];
          if (en_q[idx_q])
            phase_d[idx_q] = phase_q[idx_q] + cur_inc;
          sub_d = 1'b1;
        end else begin
          rd_addr = nxt_q;
          a_d     = tbl_data;
          vld_d   = 1'b1;
          sub_d   = 1'b0;
          if (last) state_d = DRAIN;
          else      idx_d   = idx_q + VW'(1);
        end
`else
        vld_d    = 1'b1;
        vvoice_d = idx_q;
        mute_d   = !en_q[idx_q];
        if (en_q[idx_q])
          phase_d[idx_q] = phase_q[idx_q] + cur_inc;
        if (last) state_d = DRAIN;
        else      idx_d   = idx_q + VW'(1);
`endif
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Writes land after the sweep update so a sync zero wins.
    if (freq_we && (int'(freq_voice) < VOICES)) begin
      freq_d[freq_voice] = freq_in;
      en_d[freq_voice]   = voice_on;
      if (phase_sync) phase_d[freq_voice] = '0;
    end
  end

  always_comb begin : outp
`ifdef POLY_NCO_INTERP_EN
    diff = {tbl_data[AMP_BITS-1], tbl_data} - {a_q[AMP_BITS-1], a_q};
    prod = 26'(diff) * 26'($signed({1'b0, frac_q}));
    samp = a_q + amplitude_t'(prod >>> 8);
    if (mute_q) samp = '0;
`else
    samp = mute_q ? '0 : tbl_data;
`endif
    out_valid = vld_q;
    out       = vld_q ? samp : hold_q;
    out_voice = vld_q ? vvoice_q : hvoice_q;
    hold_d    = out;
    hvoice_d  = out_voice;
  end

  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

  always_ff @(posedge clock or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      en_q      <= '0;
      vld_q     <= 1'b0;
      vvoice_q  <= '0;
      mute_q    <= 1'b0;
      overrun_q <= 1'b0;
      hold_q    <= '0;
      hvoice_q  <= '0;
      for (int v = 0; v < VOICES; v++) begin
        freq_q[v]  <= '0;
        phase_q[v] <= '0;
      end
`ifdef POLY_NCO_INTERP_EN
      sub_q  <= 1'b0;
      nxt_q  <= '0;
      frac_q <= '0;
      a_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      vld_q     <= vld_d;
      vvoice_q  <= vvoice_d;
      mute_q    <= mute_d;
      overrun_q <= overrun_d;
      hold_q    <= hold_d;
      hvoice_q  <= hvoice_d;
      freq_q    <= freq_d;
      phase_q   <= phase_d;
`ifdef POLY_NCO_INTERP_EN
      sub_q  <= sub_d;
      nxt_q  <= nxt_d;
      frac_q <= frac_d;
      a_q    <= a_d;
`endif
    end
  end

endmodule

// File: tb/tb_poly_nco.sv
// Directed bench for poly_nco: sweep timing, phase stepping, muting, overrun, reset.
// SAMPLE_RATE 65536 gives increment = freq * 256 (address step 1 per freq 1024).

module tb_poly_nco;
  import poly_nco_pkg::*;

  localparam int V = 8;
`ifdef POLY_NCO_INTERP_EN
  localparam int L0 = 3;
  localparam int ST = 2;
`else
  localparam int L0 = 2;
  localparam int ST = 1;
`endif
  localparam int LASTV = L0 + ST * (V - 1);

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         sample_tick = 1'b0;
  logic         freq_we = 1'b0;
  logic [2:0]   freq_voice = '0;
  frequency_t   freq_in = '0;
  logic         voice_on = 1'b0;
  logic         phase_sync = 1'b0;
  amplitude_t   out;
  logic [2:0]   out_voice;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  poly_nco #(.VOICES(V), .SAMPLE_RATE(65536)) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sample_tick),
    .freq_we     (freq_we),
    .freq_voice  (freq_voice),
    .freq_in     (freq_in),
    .voice_on    (voice_on),
    .phase_sync  (phase_sync),
    .out         (out),
    .out_voice   (out_voice),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit         armed = 1'b0;
  int         t0 = 0;
  int         vcnt = 0;
  int         vcyc [V];
  amplitude_t vout [V];
  bit         blog [64];

  always @(negedge clock) begin
    if (armed) begin
      int off;
      off = cyc - t0;
      if (off >= 0 && off < 64) blog[off] = busy;
      if (out_valid) begin
        vcnt = vcnt + 1;
        vcyc[out_voice] = off;
        vout[out_voice] = out;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int v, input int f, input bit on, input bit sy);
    @(posedge clock); #1;
    freq_we = 1'b1;
    freq_voice = 3'(v);
    freq_in = frequency_t'(f);
    voice_on = on;
    phase_sync = sy;
    @(posedge clock); #1;
    freq_we = 1'b0;
    phase_sync = 1'b0;
  endtask

  task automatic sweep(input int wr_off, input int wv, input int wf,
                       input int tick2);
    vcnt = 0;
    foreach (vcyc[k]) vcyc[k] = -1;
    foreach (blog[k]) blog[k] = 1'b0;
    @(posedge clock); #1;
    sample_tick = 1'b1;
    t0 = cyc;
    armed = 1'b1;
    for (int i = 1; i < L0 + ST * V + 4; i++) begin
      @(posedge clock); #1;
      sample_tick = (i == tick2);
      freq_we = (i == wr_off);
      if (i == wr_off) begin
        freq_voice = 3'(wv);
        freq_in = frequency_t'(wf);
        voice_on = 1'b1;
      end
    end
    @(negedge clock); #1;
    armed = 1'b0;
    chk("vcnt", vcnt, V);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.out", out, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ovr", overrun, 0);
    chk("rst.voice", out_voice, 0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(posedge clock);

    // all voices off
    sweep(-1, 0, 0, -1);
    for (int k = 0; k < V; k++) begin
      chk($sformatf("off.cyc%0d", k), vcyc[k], L0 + ST * k);
      chk($sformatf("off.out%0d", k), vout[k], 0);
    end
    chk("busy.T", blog[0], 0);
    chk("busy.T1", blog[1], 1);
    chk("busy.last", blog[LASTV], 1);
    chk("busy.after", blog[LASTV + 1], 0);
    chk("ovr.A0", overrun, 0);

    wr(0, 16384, 1'b1, 1'b1);
    wr(7, 16384, 1'b1, 1'b1);
    wr(1, 1024, 1'b1, 1'b1);
    wr(2, 1024, 1'b1, 1'b1);
    wr(3, 0, 1'b1, 1'b1);

    sweep(-1, 0, 0, -1);
    chk("A.v0", vout[0], 0);
    chk("A.v1", vout[1], 0);
    chk("A.v2", vout[2], 0);
    chk("A.v3", vout[3], 0);

    // write voice 2 in its own issue cycle
    sweep(1 + ST * 2, 2, 2048, -1);
    chk("B.v0", vout[0], 32767);
    chk("B.v1", vout[1], 3212);
    chk("B.v2", vout[2], 3212);
    chk("B.v3", vout[3], 0);
    chk("B.v7", vout[7], 32767);

    sweep(-1, 0, 0, -1);
    chk("C.v0", vout[0], 0);
    chk("C.v1", vout[1], 6393);
    chk("C.v2", vout[2], 6393);
    chk("C.v3", vout[3], 0);

    wr(1, 1024, 1'b0, 1'b0);
    sweep(-1, 0, 0, -1);
    chk("D.v0", vout[0], -32767);
    chk("D.v1", vout[1], 0);
    chk("D.v2", vout[2], 12539);
    chk("D.v3", vout[3], 0);
    chk("hold.valid", out_valid, 0);
    chk("hold.voice", out_voice, 7);
    chk("hold.out", out, -32767);

    wr(1, 1024, 1'b1, 1'b0);
    // second tick while busy
    sweep(-1, 0, 0, 3);
    for (int k = 0; k < V; k++)
      chk($sformatf("E.cyc%0d", k), vcyc[k], L0 + ST * k);
    chk("E.v0", vout[0], 0);
    chk("E.v1", vout[1], 9512);
    chk("E.v2", vout[2], 18204);
    chk("E.v3", vout[3], 0);
    chk("E.ovr", overrun, 1);

    sweep(-1, 0, 0, -1);
    chk("F.v0", vout[0], 32767);
    chk("F.v1", vout[1], 12539);
    chk("F.v2", vout[2], 23170);
    chk("F.ovr", overrun, 1);

`ifdef POLY_NCO_INTERP_EN
    wr(4, 512, 1'b1, 1'b1);
    wr(5, 65024, 1'b1, 1'b1);
    sweep(-1, 0, 0, -1);
    chk("G.v4", vout[4], 0);
    chk("G.v5", vout[5], 0);
    sweep(-1, 0, 0, -1);
    chk("H.v4", vout[4], 1606);
    chk("H.v5", vout[5], -1606);
    sweep(-1, 0, 0, -1);
    chk("I.v4", vout[4], 3212);
    sweep(-1, 0, 0, -1);
    chk("J.v4", vout[4], 4802);
`endif

    // reset in the middle of a sweep
    @(posedge clock); #1;
    sample_tick = 1'b1;
    t0 = cyc;
    armed = 1'b1;
    @(posedge clock); #1 sample_tick = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    vcnt = 0;
    @(negedge clock);
    chk("mid.busy", busy, 0);
    chk("mid.valid", out_valid, 0);
    chk("mid.ovr", overrun, 0);
    chk("mid.out", out, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    sample_tick = 1'b1;
    @(posedge clock); #1 sample_tick = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock); #1;
    chk("mid.novalid", vcnt, 0);
    armed = 1'b0;

    sweep(-1, 0, 0, -1);
    chk("R.v0", vout[0], 0);
    chk("R.v1", vout[1], 0);
    chk("R.cyc7", vcyc[7], LASTV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
